// File: rtl/mem_reinit_ram.sv
// Simple dual-port RAM with configurable read latency, read-during-write mode and a runtime clear engine.
// Optional: define MEM_REINIT_OOB_CHK_EN to add the sticky oob_err flag and suppress out-of-range accesses.
module mem_reinit_ram #(
  parameter string               F_INIT     = "init.txt",
  parameter int                  INIT_ISHEX = 1,
  parameter int                  WID_MEM    = 4,
  parameter int                  DEPTH_MEM  = 32768,
  parameter int                  ADDR_W     = 32,
  parameter int                  RD_LAT     = 1,
  parameter int                  RDW_MODE   = 0,
  parameter logic [WID_MEM-1:0]  CLR_VAL    = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [WID_MEM-1:0] din,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [WID_MEM-1:0] dout,
  output logic               dout_vld,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_done
`ifdef MEM_REINIT_OOB_CHK_EN
  ,
  output logic               oob_err
`endif
);

  localparam int               IDX_W   = $clog2(DEPTH_MEM);
  localparam logic [IDX_W:0]   DEPTH_I = (IDX_W+1)'(DEPTH_MEM);
  localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(DEPTH_MEM - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  logic [WID_MEM-1:0] r_mem [DEPTH_MEM];

  state_t             r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [IDX_W-1:0]   w_widx;
  logic [IDX_W-1:0]   w_ridx;
  logic               w_wok;
  logic               w_rok;
  logic               w_clr_wr;
  logic               w_usr_wr;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [WID_MEM-1:0] w_wr_dat;

  logic [WID_MEM-1:0] r_rdat_p0;
  logic [WID_MEM-1:0] r_bdat_p0;
  logic               r_byp_p0;
  logic               r_rzero_p0;
  logic               r_vld_p0;
  logic [WID_MEM-1:0] w_dout_p0;

  assign w_widx = waddr[IDX_W-1:0];
  assign w_ridx = raddr[IDX_W-1:0];

`ifdef MEM_REINIT_OOB_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH_MEM);
  logic w_woob;
  logic w_roob;
  logic r_oob;

  assign w_woob = {1'b0, waddr} >= DEPTH_A;
  assign w_roob = {1'b0, raddr} >= DEPTH_A;
  assign w_wok  = ~w_woob;
  assign w_rok  = ~w_roob;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_oob <= 1'b0;
    end else if ((we && w_woob) || (re && w_roob)) begin
      r_oob <= 1'b1;
    end
  end

  assign oob_err = r_oob;
`else
  // Upper address bits are deliberately ignored; indices past a non-power-of-2 depth are no-ops.
  logic w_unused_addr;
  assign w_unused_addr = ^{waddr[ADDR_W-1:IDX_W], raddr[ADDR_W-1:IDX_W]};
  assign w_wok = {1'b0, w_widx} < DEPTH_I;
  assign w_rok = {1'b0, w_ridx} < DEPTH_I;
`endif

  // The clear engine owns the write port while busy; user writes only land in IDLE.
  always_comb begin
    w_clr_wr = (r_state == S_CLEAR) && reset;
    w_usr_wr = we && (r_state == S_IDLE) && w_wok;
    w_wr_en  = w_clr_wr || w_usr_wr;
    w_wr_idx = w_clr_wr ? r_cnt : w_widx;
    w_wr_dat = w_clr_wr ? CLR_VAL : din;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_dat;
    if (re) begin
      r_rdat_p0 <= r_mem[w_ridx];
      r_bdat_p0 <= w_wr_dat;
    end
  end

  // ---- stage p0: RAM output register plus bypass/zero select ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld_p0   <= 1'b0;
      r_byp_p0   <= 1'b0;
      r_rzero_p0 <= 1'b1;
    end else begin
      r_vld_p0 <= re;
      if (re) begin
        r_rzero_p0 <= ~w_rok;
        r_byp_p0   <= (RDW_MODE != 0) && w_wr_en && (w_wr_idx == w_ridx);
      end
    end
  end

  assign w_dout_p0 = r_rzero_p0 ? '0 : (r_byp_p0 ? r_bdat_p0 : r_rdat_p0);

  // ---- stage p1: optional output register ----
  if (RD_LAT == 2) begin : g_lat2
    logic [WID_MEM-1:0] r_dout_p1;
    logic               r_vld_p1;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_dout_p1 <= '0;
        r_vld_p1  <= 1'b0;
      end else begin
        r_vld_p1 <= r_vld_p0;
        if (r_vld_p0) r_dout_p1 <= w_dout_p0;
      end
    end

    assign dout     = r_dout_p1;
    assign dout_vld = r_vld_p1;
  end else begin : g_lat1
    assign dout     = w_dout_p0;
    assign dout_vld = r_vld_p0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_I) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clr_busy = r_busy;
  assign clr_done = r_done;

endmodule

// File: tb/tb_mem_reinit_ram.sv
// Scoreboard bench for mem_reinit_ram: two instances (16-deep/latency 1/read-first, 12-deep/latency 2/write-first) share stimulus.
module tb_mem_reinit_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] waddr;
  logic [3:0]  din;
  logic        re;
  logic [31:0] raddr;
  logic        clr_req;

  logic [3:0]  a_dout, b_dout;
  logic        a_vld, b_vld, a_busy, b_busy, a_done, b_done;
`ifdef MEM_REINIT_OOB_CHK_EN
  logic        a_oob, b_oob;
  localparam bit OOB = 1'b1;
`else
  localparam bit OOB = 1'b0;
`endif

  typedef struct {
    logic [3:0] d;
    int         c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] DA [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'hB, 4'hD, 4'h3,
                          4'h9, 4'hE, 4'h7, 4'h5, 4'hA, 4'hC, 4'h1, 4'h2};
  logic [3:0] DB [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'hB, 4'hD, 4'h3,
                          4'h9, 4'hE, 4'h7, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_reinit_ram #(
    .F_INIT(""), .INIT_ISHEX(1), .WID_MEM(4), .DEPTH_MEM(16), .ADDR_W(32),
    .RD_LAT(1), .RDW_MODE(0), .CLR_VAL(4'hF)
  ) u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(a_dout), .dout_vld(a_vld),
`ifdef MEM_REINIT_OOB_CHK_EN
    .oob_err(a_oob),
`endif
    .clr_req(clr_req), .clr_busy(a_busy), .clr_done(a_done)
  );

  mem_reinit_ram #(
    .F_INIT(""), .INIT_ISHEX(1), .WID_MEM(4), .DEPTH_MEM(12), .ADDR_W(32),
    .RD_LAT(2), .RDW_MODE(1), .CLR_VAL(4'h5)
  ) u_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(b_dout), .dout_vld(b_vld),
`ifdef MEM_REINIT_OOB_CHK_EN
    .oob_err(b_oob),
`endif
    .clr_req(clr_req), .clr_busy(b_busy), .clr_done(b_done)
  );

  // Monitor: every valid read must match the oldest expectation, in value and in arrival cycle.
  always @(negedge clk) begin
    if (a_vld) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL rdA_unexpected: got %0h with no read outstanding", a_dout);
      end else begin
        ea = qa.pop_front();
        if (a_dout !== ea.d || cyc != ea.c) begin
          n_err++;
          $display("FAIL rdA: got %0h at cycle %0d, expected %0h at cycle %0d", a_dout, cyc, ea.d, ea.c);
        end
      end
    end
    if (b_vld) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL rdB_unexpected: got %0h with no read outstanding", b_dout);
      end else begin
        eb = qb.pop_front();
        if (b_dout !== eb.d || cyc != eb.c) begin
          n_err++;
          $display("FAIL rdB: got %0h at cycle %0d, expected %0h at cycle %0d", b_dout, cyc, eb.d, eb.c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] d);
    we = 1'b1;
    waddr = a;
    din = d;
    tick();
  endtask

  // Issue a read without advancing time; A answers one edge later, B two.
  task automatic rd_issue(input logic [31:0] a, input logic [3:0] xa, input logic [3:0] xb);
    re = 1'b1;
    raddr = a;
    qa.push_back('{xa, cyc + 1});
    qb.push_back('{xb, cyc + 2});
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] xa, input logic [3:0] xb);
    rd_issue(a, xa, xb);
    tick();
  endtask

  int a_bcnt, b_bcnt, a_dcnt, b_dcnt;

  initial begin
    reset = 1'b0;
    idle();
    waddr = '0;
    raddr = '0;
    din = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_doutA", a_dout, 0);
    chk("rst_vldA", a_vld, 0);
    chk("rst_busyA", a_busy, 0);
    chk("rst_doneA", a_done, 0);
    chk("rst_doutB", b_dout, 0);
    chk("rst_vldB", b_vld, 0);
    chk("rst_busyB", b_busy, 0);
    chk("rst_doneB", b_done, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) wr(i, DA[i]);
    idle();
`ifdef MEM_REINIT_OOB_CHK_EN
    chk("oobA_clean", a_oob, 0);
    chk("oobB_set", b_oob, 1);
`endif
    for (int i = 0; i < 16; i++) rd(i, DA[i], DB[i]);
    idle();
    tick();

    // Same-address read during write at index 7 (old 3, new C)
    we = 1'b1; waddr = 7; din = 4'hC;
    rd(7, 4'h3, 4'hC);
    we = 1'b0;
    rd(7, 4'hC, 4'hC);
    idle();
    repeat (3) tick();
    @(negedge clk);
    chk("holdA", a_dout, 4'hC);
    chk("hold_vldA", a_vld, 0);
    chk("holdB", b_dout, 4'hC);
    chk("hold_vldB", b_vld, 0);
    tick();

    // Upper address bits: aliases index 2 by default, suppressed when range-checked
    wr(32'h12, 4'h6);
    we = 1'b0;
    rd(2, OOB ? 4'h4 : 4'h6, OOB ? 4'h4 : 4'h6);
    rd(32'h102, OOB ? 4'h0 : 4'h6, OOB ? 4'h0 : 4'h6);
    idle();
    tick();

    // Clear sweep; a user write in the same cycle as clr_req commits and is then overwritten
    we = 1'b1; waddr = 4; din = 4'h9; clr_req = 1'b1;
    tick();
    idle();
    a_bcnt = 0; b_bcnt = 0; a_dcnt = 0; b_dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a_bcnt += int'(a_busy);
      b_bcnt += int'(b_busy);
      a_dcnt += int'(a_done);
      b_dcnt += int'(b_done);
      if (k == 5) begin
        // write to already-cleared word 1 and a repeated clr_req must both be ignored;
        // read of word 5 collides with its clear write
        we = 1'b1; waddr = 1; din = 4'h2; clr_req = 1'b1;
        rd_issue(5, 4'hB, 4'h5);
      end else if (k == 6) begin
        we = 1'b0; clr_req = 1'b0;
        rd_issue(0, 4'hF, 4'h5);
      end else if (k == 7) begin
        idle();
      end
    end
    tick();
    chk("busy_cyclesA", a_bcnt, 17);
    chk("busy_cyclesB", b_bcnt, 13);
    chk("done_pulsesA", a_dcnt, 1);
    chk("done_pulsesB", b_dcnt, 1);
    for (int i = 0; i < 16; i++) rd(i, 4'hF, (i < 12) ? 4'h5 : 4'h0);
    idle();
    tick();

    // Reset in the middle of a sweep: words 0..7 cleared, the rest keep their data
    for (int i = 0; i < 16; i++) wr(i, DA[i]);
    idle();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("busy_midA", a_busy, 1);
    chk("busy_midB", b_busy, 1);
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("busy_abortA", a_busy, 0);
    chk("busy_abortB", b_busy, 0);
    chk("done_abortA", a_done, 0);
`ifdef MEM_REINIT_OOB_CHK_EN
    chk("oobB_reset", b_oob, 0);
`endif
    reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) rd(i, (i < 8) ? 4'hF : DA[i], (i < 8) ? 4'h5 : DB[i]);
    idle();
    repeat (5) tick();
    chk("drainA", qa.size(), 0);
    chk("drainB", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
